// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned INST_W     = 32;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;

    localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OP_DEFAULT = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular instruction buffer; stores an instruction word with its address tag.
module fetch_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [DATA_W-1:0]         push_data,
    input  logic [TAG_W-1:0]          push_tag,
    output logic [DATA_W-1:0]         head_data,
    output logic [TAG_W-1:0]          head_tag,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned IW = $clog2(DEPTH);

    logic [IW:0]              wr_q, wr_d, rd_q, rd_d;
    logic [DATA_W+TAG_W-1:0]  mem_q [DEPTH];
    logic [DATA_W+TAG_W-1:0]  mem_d [DEPTH];

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[IW] != rd_q[IW]) && (wr_q[IW-1:0] == rd_q[IW-1:0]);
    assign count = wr_q - rd_q;

    // Head is masked so decode never sees stale storage when the buffer is empty.
    assign {head_data, head_tag} = empty ? '0 : mem_q[rd_q[IW-1:0]];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q[IW-1:0]] = {push_data, push_tag};
                wr_d = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, sequences memory reads, handles start/redirect/halt.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]                RESET_PC   = 16'h0000,
    parameter int unsigned                      FIFO_DEPTH = 2,
    parameter logic [OPCODE_MSB-OPCODE_LSB:0]   HALT_OP    = HALT_OP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] inst_address,
    input  logic [INST_W-1:0] read_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              busy,
    output logic              halted
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;

    logic               push, pop, flush;
    logic               full, empty;
    logic [CW-1:0]      count;

    assign inst_address = pc_q;
    assign inst_valid   = !empty;
    assign pop          = inst_valid && inst_ready;
    assign busy         = busy_q;
    assign halted       = halted_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = redirect_addr;
                    state_d = ST_RUN;
                end else if (state_q == ST_RUN) begin
                    if (!full || pop) begin
                        push = 1'b1;
                        // The halt word itself is delivered; PC stays on it.
                        if (read_data[OPCODE_MSB:OPCODE_LSB] == HALT_OP) begin
                            state_d = ST_DRAIN;
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
                    end
                end else if (empty || (pop && count == CW'(1))) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (redirect_valid) begin
                    state_d = ST_RUN;
                    pc_d    = redirect_addr;
                end else if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d   = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    fetch_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (INST_W),
        .TAG_W  (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data (read_data),
        .push_tag  (pc_q),
        .head_data (inst_data),
        .head_tag  (inst_pc),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a queue-based behavioural model.
module tb_fetch_sequencer;

    localparam logic [15:0] RPC   = 16'h0000;
    localparam int          DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic [15:0] inst_address;
    logic [31:0] read_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [15:0] inst_pc;
    logic        busy;
    logic        halted;

    logic [31:0] mem [256];
    assign read_data = mem[inst_address[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH),
        .HALT_OP    (6'h3F)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .inst_address   (inst_address),
        .read_data      (read_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .busy           (busy),
        .halted         (halted)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a queue of delivered-to-be words, a PC, and the four operating modes.
    typedef struct {
        logic [31:0] d;
        logic [15:0] a;
    } ent_t;
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_HALTED} mode_t;

    ent_t        q[$];
    mode_t       mode;
    logic [15:0] m_pc;

    function automatic logic [31:0] plain_word();
        logic [31:0] w;
        w = $urandom | 32'h1;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    task automatic model_step(input logic r, input logic st, input logic rv,
                              input logic [15:0] ra, input logic rdy);
        bit   popped;
        ent_t e;
        popped = (q.size() > 0) && rdy;
        if (r) begin
            q.delete();
            m_pc = RPC;
            mode = M_IDLE;
        end else begin
            case (mode)
                M_IDLE: if (st) begin mode = M_RUN; m_pc = RPC; end
                M_RUN, M_DRAIN: begin
                    if (rv) begin
                        q.delete();
                        m_pc = ra;
                        mode = M_RUN;
                    end else begin
                        bit room;
                        room = (q.size() < DEPTH) || popped;
                        if (popped) void'(q.pop_front());
                        if (mode == M_RUN) begin
                            if (room) begin
                                e.d = mem[m_pc[7:0]];
                                e.a = m_pc;
                                q.push_back(e);
                                if (e.d[31:26] == 6'h3F) mode = M_DRAIN;
                                else m_pc = m_pc + 16'd1;
                            end
                        end else if (q.size() == 0) begin
                            mode = M_HALTED;
                        end
                    end
                end
                M_HALTED: begin
                    if (rv) begin mode = M_RUN; m_pc = ra; end
                    else if (st) begin mode = M_RUN; m_pc = RPC; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_outputs();
        check_eq("inst_valid",   inst_valid,   q.size() > 0);
        check_eq("inst_data",    inst_data,    q.size() > 0 ? q[0].d : 32'h0);
        check_eq("inst_pc",      inst_pc,      q.size() > 0 ? q[0].a : 16'h0);
        check_eq("inst_address", inst_address, m_pc);
        check_eq("busy",         busy,         mode == M_RUN || mode == M_DRAIN);
        check_eq("halted",       halted,       mode == M_HALTED);
    endtask

    // Drive one cycle of inputs at the negedge, advance model and DUT, then compare.
    task automatic step(input logic r, input logic st, input logic rv,
                        input logic [15:0] ra, input logic rdy);
        rst            = r;
        start          = st;
        redirect_valid = rv;
        redirect_addr  = ra;
        inst_ready     = rdy;
        model_step(r, st, rv, ra, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = plain_word();
        q.delete();
        mode = M_IDLE;
        m_pc = RPC;
        rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; inst_ready = 1'b0;
        @(negedge clk);

        // Reset state and streaming from RESET_PC with inst_ready held high.
        step(1, 0, 0, 16'h0, 0);
        step(1, 0, 0, 16'h0, 0);
        step(0, 1, 0, 16'h0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 16'h0, 1);

        // Redirect to 0x0040 while popping.
        step(0, 0, 1, 16'h0040, 1);
        check_eq("redir_valid_drop", inst_valid, 1'b0);
        check_eq("redir_addr", inst_address, 16'h0040);
        step(0, 0, 0, 16'h0, 1);
        check_eq("redir_first_pc", inst_pc, 16'h0040);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0, 1);

        // Backpressure right after start: buffer fills, PC stalls at 2, head is addr 0.
        step(1, 0, 0, 16'h0, 0);
        step(0, 1, 0, 16'h0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0, 0);
        check_eq("stall_head_pc", inst_pc, 16'h0);
        check_eq("stall_addr", inst_address, 16'h2);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 16'h0, 1);

        // Halt opcode at address 3, then restart, then redirect out of HALTED to 0xFFFF.
        mem[3] = {6'h3F, 26'h0ABCDE};
        step(1, 0, 0, 16'h0, 1);
        step(0, 1, 0, 16'h0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 16'h0, 1);
        check_eq("halt_state", halted, 1'b1);
        check_eq("halt_addr_hold", inst_address, 16'h3);
        step(0, 1, 0, 16'h0, 1);
        check_eq("restart_addr", inst_address, 16'h0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 16'h0, 1);
        step(0, 0, 1, 16'hFFFF, 1);
        check_eq("wrap_addr", inst_address, 16'hFFFF);
        step(0, 0, 0, 16'h0, 1);
        check_eq("wrap_pc0", inst_pc, 16'hFFFF);
        step(0, 0, 0, 16'h0, 1);
        check_eq("wrap_pc1", inst_pc, 16'h0000);
        step(0, 0, 0, 16'h0, 1);
        check_eq("wrap_pc2", inst_pc, 16'h0001);
        mem[3] = plain_word();

        // Reset while the buffer is full in RUN.
        step(1, 0, 0, 16'h0, 0);
        step(0, 1, 0, 16'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0, 0);
        step(1, 0, 0, 16'h0, 0);
        check_eq("rst_valid", inst_valid, 1'b0);
        check_eq("rst_addr", inst_address, RPC);
        check_eq("rst_busy", busy, 1'b0);

        // Randomized traffic with sparse halt words.
        for (int i = 0; i < 256; i++) begin
            mem[i] = plain_word();
            if ($urandom_range(0, 19) == 0) mem[i][31:26] = 6'h3F;
        end
        for (int i = 0; i < 3000; i++) begin
            logic        r, st, rv, rdy;
            logic [15:0] ra;
            r   = ($urandom_range(0, 199) == 0);
            st  = ($urandom_range(0, 19) == 0);
            rv  = ($urandom_range(0, 24) == 0);
            ra  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            step(r, st, rv, ra, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences reads from the 256-word, 32-bit, combinational-read instruction memory. Each accepted fetch is pushed into a small instruction buffer that feeds the decode stage over a valid/ready handshake. The block handles start, branch/jump redirect with buffer flush, and halt-opcode detection with drain. It sits between the instruction memory and decode in the processor datapath.

## Interface

Parameters:
- RESET_PC, 16'h0000, word address loaded on reset and on `start`
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2)
- HALT_OP, 6'h3F, opcode value in read_data[31:26] that ends fetching

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin fetching from RESET_PC; honoured in IDLE and HALTED only
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_addr  in  16  new word address, used when redirect_valid=1
- inst_address  out  16  word address to instruction memory; equals PC register
- read_data  in  32  instruction memory data for inst_address (same-cycle combinational)
- inst_valid  out  1  buffer head holds a valid instruction
- inst_ready  in  1  decode accepts head this cycle
- inst_data  out  32  head instruction; 0 when buffer empty
- inst_pc  out  16  address of head instruction; 0 when buffer empty
- busy  out  1  state is RUN or DRAIN
- halted  out  1  state is HALTED

## Operation

- States: IDLE, RUN, DRAIN, HALTED. Reset → IDLE, PC=RESET_PC, buffer empty.
- IDLE: start → RUN. PC=RESET_PC. Redirect is ignored.
- RUN: fetch happens when buffer not full, or when full and pop occurs in the same cycle. Fetch pushes {read_data, PC}; PC←PC+1.
- RUN: a fetched word with opcode == HALT_OP is still pushed. PC is not incremented, and state → DRAIN.
- DRAIN: no fetches. When buffer is empty (after pop) → HALTED.
- HALTED: start → RUN with PC=RESET_PC. redirect_valid → RUN with PC=redirect_addr.
- Pop: inst_valid & inst_ready.
- Redirect (RUN or DRAIN): a pop in the same cycle completes. Buffer is flushed, PC←redirect_addr, and no fetch occurs that cycle. State → RUN.
- Priority: rst > redirect > halt detection > normal fetch. start is ignored in RUN/DRAIN.
- PC arithmetic: 16-bit, wraps 16'hFFFF → 16'h0000. No bounds check against memory depth.
- Buffer: circular, pointers log2(FIFO_DEPTH)+1 bits, full/empty from the pointer MSB compare.

## Timing

- Reset values: inst_valid=0, inst_data=0, inst_pc=0, busy=0, halted=0, inst_address=RESET_PC.
- start sampled in cycle N. RUN in N+1 with inst_address=RESET_PC. inst_valid=1 in N+2 with inst_pc=RESET_PC.
- Fetch-to-valid latency is 1 cycle. Sustained throughput is 1 instruction/cycle while inst_ready=1.
- Redirect sampled in cycle N. inst_valid=0 in N+1, inst_address=redirect_addr in N+1, first new instruction valid in N+2.
- inst_data and inst_pc are stable while inst_valid=1 and inst_ready=0.
- rst mid-operation: the next cycle shows the full reset values and discards buffer contents.

## Structure

- Package fetch_pkg holds: state enum, OPCODE_MSB=31, OPCODE_LSB=26, default HALT_OP, address width 16, instruction width 32.
- Sub-module fetch_fifo holds the synchronous circular buffer. Its ports are push/pop/flush plus data and tag. It outputs full/empty. flush has priority over push.
- Top level holds the FSM, the PC, and the fetch-enable logic.

## Test plan

- start with RESET_PC=0, memory words 0..5 nonzero, inst_ready=1 → inst_pc 0,1,2,3,… on consecutive cycles from cycle 2.
- inst_ready=0 for 5 cycles → exactly 2 entries buffered, PC stalls at 2, and head holds addr 0. Release inst_ready → 0,1,2 delivered with no gap.
- redirect_valid with redirect_addr=16'h0040 mid-stream while popping → the popped word is counted, old entries are discarded, and next inst_pc=16'h0040.
- HALT_OP word at addr 3 → words 0..3 delivered, halted=1 one cycle after the last pop, and inst_address held at 3. Then start → refetch from 0.
- Redirect to 16'hFFFF → inst_pc sequence FFFF, 0000, 0001.
- rst asserted while buffer is full in RUN → the next cycle shows IDLE, inst_valid=0, and inst_address=RESET_PC.
